sam_rv32i_commit_trace: RTL and testbench

- Debug/trace stage directly downstream of the sam_rv32i core. It consumes the core's NPC and WB_OUT outputs every clock.
- Each time NPC changes, it records a commit event {seq, pc, wb} into a small FIFO.
- A valid/ready port lets a host-side drainer (UART bridge or testbench scoreboard) pull events. The core is never back-pressured.
- Events that arrive while the FIFO is full are dropped and counted.

---
 rtl/sam_rv32i_pkg.sv | 17 +
 rtl/sam_sync_fifo.sv | 57 +++++
 rtl/sam_rv32i_commit_trace.sv | 85 ++++++++
 tb/tb_sam_rv32i_commit_trace.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sam_rv32i_pkg.sv
// Shared definitions for the sam_rv32i core and its commit-trace stage.
package sam_rv32i_pkg;

    localparam int XLEN        = 32;
    localparam int TRACE_DEPTH = 8;
    localparam int TRACE_SEQ_W = 16;

    // One commit event as it sits in the trace FIFO (default widths).
    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        wb;
    } trace_entry_t;

    localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/sam_sync_fifo.sv
// Generic synchronous show-ahead FIFO; head word is visible on dout whenever not empty.
module sam_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Pop of an empty FIFO is ignored; a push into a full FIFO needs a same-edge pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sam_rv32i_commit_trace.sv
// Commit-trace stage: turns NPC changes into {seq, pc, wb} events queued for a host drainer.
module sam_rv32i_commit_trace #(
    parameter int XLEN  = sam_rv32i_pkg::XLEN,
    parameter int DEPTH = sam_rv32i_pkg::TRACE_DEPTH,
    parameter int SEQ_W = sam_rv32i_pkg::TRACE_SEQ_W
) (
    input  logic                     clk,
    input  logic                     RN,
    input  logic                     clr,
    input  logic                     en,
    input  logic [XLEN-1:0]          npc_in,
    input  logic [XLEN-1:0]          wb_in,
    output logic                     trc_valid,
    input  logic                     trc_ready,
    output logic [SEQ_W-1:0]         trc_seq,
    output logic [XLEN-1:0]          trc_pc,
    output logic [XLEN-1:0]          trc_wb,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [SEQ_W-1:0]         drop_cnt
);

    localparam int EW = SEQ_W + 2 * XLEN;

    logic [SEQ_W-1:0] seq_q;
    logic [XLEN-1:0]  last_npc;
    logic             seen;
    logic             evt;
    logic             push;
    logic             pop;
    logic             drop;
    logic [EW-1:0]    head;

    // Handshake: an entry transfers on a rising edge where trc_valid && trc_ready;
    // trc_valid never depends on trc_ready, and the head holds until it transfers.
    assign trc_valid = !empty;
    assign pop       = trc_valid && trc_ready;

    // The very first enabled cycle after clear always counts as a commit.
    assign evt  = en && !RN && !clr && (!seen || npc_in != last_npc);
    assign push = evt && (!full || pop);
    assign drop = evt && full && !pop;

    sam_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (RN),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   ({seq_q, npc_in, wb_in}),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign {trc_seq, trc_pc, trc_wb} = head;

    always_ff @(posedge clk) begin
        if (RN || clr) begin
            seq_q    <= '0;
            last_npc <= '0;
            seen     <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (en) begin
                last_npc <= npc_in;
                seen     <= 1'b1;
            end
            // Dropped events still consume a sequence number so gaps reveal loss.
            if (evt) seq_q <= seq_q + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sam_rv32i_commit_trace.sv
// Directed bench for sam_rv32i_commit_trace with a scoreboard on drained entries.
module tb_sam_rv32i_commit_trace;
    import sam_rv32i_pkg::*;

    localparam int DEPTH = TRACE_DEPTH;
    localparam int SEQ_W = TRACE_SEQ_W;
    localparam int EW    = TRACE_ENTRY_W;

    logic                   clk = 1'b0;
    logic                   RN = 1'b1;
    logic                   clr = 1'b0;
    logic                   en = 1'b0;
    logic [XLEN-1:0]        npc_in = '0;
    logic [XLEN-1:0]        wb_in = '0;
    logic                   trc_valid;
    logic                   trc_ready = 1'b0;
    logic [SEQ_W-1:0]       trc_seq;
    logic [XLEN-1:0]        trc_pc;
    logic [XLEN-1:0]        trc_wb;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic                   overflow;
    logic [SEQ_W-1:0]       drop_cnt;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    sam_rv32i_commit_trace dut (
        .clk       (clk),
        .RN        (RN),
        .clr       (clr),
        .en        (en),
        .npc_in    (npc_in),
        .wb_in     (wb_in),
        .trc_valid (trc_valid),
        .trc_ready (trc_ready),
        .trc_seq   (trc_seq),
        .trc_pc    (trc_pc),
        .trc_wb    (trc_wb),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [EW-1:0] mk(input int seq, input logic [XLEN-1:0] pc,
                                         input logic [XLEN-1:0] wb);
        trace_entry_t e;
        e.seq = SEQ_W'(seq);
        e.pc  = pc;
        e.wb  = wb;
        return e;
    endfunction

    // driver: apply inputs, then advance one edge and settle
    task automatic step(input logic [XLEN-1:0] npc, input logic [XLEN-1:0] wb);
        npc_in = npc;
        wb_in  = wb;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 40;
        trc_ready = 1'b1;
        while (!empty && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check(tag, empty, 1);
        check({tag, "_q"}, exp_q.size(), 0);
        trc_ready = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, trc_valid, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_count"}, count, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_drop"}, drop_cnt, 0);
        check({tag, "_head"}, {trc_seq, trc_pc, trc_wb}, 0);
    endtask

    // scoreboard: every transferring head must match the oldest expectation
    always @(negedge clk) begin
        if (!RN && !clr && trc_valid && trc_ready) begin
            if (exp_q.size() == 0) check("sb_extra", {trc_seq, trc_pc, trc_wb}, 0);
            else check("sb_head", {trc_seq, trc_pc, trc_wb}, exp_q.pop_front());
        end
    end

    initial begin
        // 1: reset, first event latency, held NPC
        RN = 1'b1;
        step(0, 0);
        step(0, 0);
        check_cleared("rst");
        check("rst_full", full, 0);
        RN = 1'b0;
        en = 1'b1;
        step(32'h4, 32'h44);
        check("t1_valid", trc_valid, 1);
        check("t1_seq", trc_seq, 0);
        check("t1_pc", trc_pc, 32'h4);
        repeat (5) step(32'h4, 32'h55);
        check("t1_hold_count", count, 1);
        check("t1_hold_pc", trc_pc, 32'h4);
        clr = 1'b1;
        step(32'h4, 0);
        clr = 1'b0;
        check_cleared("t1_clr");

        // 2: streaming drain
        trc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(i, XLEN'(4 * i), XLEN'(32'h10 + i)));
            step(XLEN'(4 * i), XLEN'(32'h10 + i));
        end
        drain("t2_drain");
        check("t2_count", count, 0);

        // 3: overflow with drops
        clr = 1'b1;
        step(32'hc, 0);
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < DEPTH) exp_q.push_back(mk(i, XLEN'(32'h100 + 4 * i), XLEN'(32'h1000 + i)));
            step(XLEN'(32'h100 + 4 * i), XLEN'(32'h1000 + i));
        end
        check("t3_full", full, 1);
        check("t3_count", count, 8);
        check("t3_drop", drop_cnt, 2);
        check("t3_ovf", overflow, 1);
        drain("t3_drain");
        step(32'h200, 32'h2000);
        check("t3_next_seq", trc_seq, 10);
        exp_q.push_back(mk(10, 32'h200, 32'h2000));

        // 4: push into full FIFO with same-edge pop
        for (int i = 1; i < DEPTH; i++) begin
            exp_q.push_back(mk(10 + i, XLEN'(32'h200 + 4 * i), XLEN'(32'h2000 + i)));
            step(XLEN'(32'h200 + 4 * i), XLEN'(32'h2000 + i));
        end
        check("t4_full_count", count, 8);
        trc_ready = 1'b1;
        exp_q.push_back(mk(18, 32'h280, 32'h2800));
        step(32'h280, 32'h2800);
        check("t4_count", count, 8);
        check("t4_drop", drop_cnt, 2);
        drain("t4_drain");

        // 5: clr then RN mid-operation
        step(32'h500, 0);
        step(32'h504, 0);
        step(32'h508, 0);
        check("t5_count", count, 3);
        clr = 1'b1;
        step(32'h508, 0);
        clr = 1'b0;
        check_cleared("t5_clr");
        step(32'h600, 32'h6);
        check("t5_clr_seq", trc_seq, 0);
        check("t5_clr_pc", trc_pc, 32'h600);
        step(32'h604, 0);
        step(32'h608, 0);
        check("t5_count2", count, 3);
        RN = 1'b1;
        step(32'h608, 0);
        RN = 1'b0;
        check_cleared("t5_rn");
        step(32'h700, 32'h7);
        check("t5_rn_seq", trc_seq, 0);
        check("t5_rn_pc", trc_pc, 32'h700);

        // 6: en gating
        clr = 1'b1;
        step(32'h700, 0);
        clr = 1'b0;
        en = 1'b0;
        step(32'h20, 0);
        step(32'h24, 0);
        check("t6_gated", count, 0);
        en = 1'b1;
        step(32'h24, 32'h99);
        check("t6_count", count, 1);
        check("t6_head", {trc_seq, trc_pc, trc_wb}, mk(0, 32'h24, 32'h99));
        repeat (3) step(32'h24, 32'h98);
        check("t6_hold", count, 1);
        exp_q.push_back(mk(0, 32'h24, 32'h99));
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
